// File: rtl/sirv_rst_seq_ctrl.sv
// rtl/sirv_rst_seq_ctrl.sv - staged domain reset release sequencer
// Holds all domains in reset, waits for PLL lock, then releases domains 0, 1, 2 in turn.
module sirv_rst_seq_ctrl #(
  parameter int HOLD_CYC = 16,
  parameter int STEP_CYC = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       test_mode,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  input  logic       wdog_rst_req,
  output logic       rst_dom0,
  output logic       rst_dom1,
  output logic       rst_dom2,
  output logic       seq_busy,
  output logic       seq_done,
  output logic [1:0] rst_cause
);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_LOCK,
    ST_STEP1,
    ST_STEP2,
    ST_RUN
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
  localparam logic [7:0] STEP_LAST = 8'(STEP_CYC - 1);

  localparam logic [1:0] CAUSE_SW   = 2'd1;
  localparam logic [1:0] CAUSE_WDOG = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pll_sync_q, pll_sync_d;
  logic       lock_s_q, lock_s_d;
  logic [1:0] cause_q, cause_d;
  logic       rst_dom0_q, rst_dom0_d;
  logic       rst_dom1_q, rst_dom1_d;
  logic       rst_dom2_q, rst_dom2_d;
  logic       seq_busy_q, seq_busy_d;
  logic       seq_done_q, seq_done_d;
  logic       lock_loss;
  logic       restart;

  always_comb begin
    pll_sync_d = pll_lock;
    lock_s_d   = pll_sync_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;

    // Lock loss only matters once the domains are all running.
    lock_loss = (state_q == ST_RUN) && !lock_s_q;
    restart   = wdog_rst_req || sw_rst_req || lock_loss;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_LOCK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STEP1;
          cnt_d   = 8'd0;
        end
      end
      ST_STEP1: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_STEP2;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STEP2: begin
        if (cnt_q == STEP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        cnt_d = 8'd0;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = 8'd0;
      end
    endcase

    if (restart) begin
      state_d = ST_HOLD;
      cnt_d   = 8'd0;
      if (wdog_rst_req)   cause_d = CAUSE_WDOG;
      else if (lock_loss) cause_d = CAUSE_LOCK;
      else                cause_d = CAUSE_SW;
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    rst_dom0_d = !((state_d == ST_STEP1) || (state_d == ST_STEP2) || (state_d == ST_RUN));
    rst_dom1_d = !((state_d == ST_STEP2) || (state_d == ST_RUN));
    rst_dom2_d = (state_d != ST_RUN);
    seq_busy_d = (state_d != ST_RUN);
    seq_done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      cnt_q      <= 8'd0;
      pll_sync_q <= 1'b0;
      lock_s_q   <= 1'b0;
      cause_q    <= 2'd0;
      rst_dom0_q <= 1'b1;
      rst_dom1_q <= 1'b1;
      rst_dom2_q <= 1'b1;
      seq_busy_q <= 1'b1;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_sync_q <= pll_sync_d;
      lock_s_q   <= lock_s_d;
      cause_q    <= cause_d;
      rst_dom0_q <= rst_dom0_d;
      rst_dom1_q <= rst_dom1_d;
      rst_dom2_q <= rst_dom2_d;
      seq_busy_q <= seq_busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  // DFT bypass: domain resets follow the block reset directly.
  assign rst_dom0  = test_mode ? reset : rst_dom0_q;
  assign rst_dom1  = test_mode ? reset : rst_dom1_q;
  assign rst_dom2  = test_mode ? reset : rst_dom2_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_sirv_rst_seq_ctrl.sv
// tb/tb_sirv_rst_seq_ctrl.sv - self-checking bench for sirv_rst_seq_ctrl
// Directed schedule checks plus randomized stimulus against a cycle-age reference model.
module tb_sirv_rst_seq_ctrl;

  localparam int HOLD = 16;
  localparam int STEP = 8;
  localparam int RELMAX = 2 * STEP + 1;

  logic       clock;
  logic       reset;
  logic       test_mode;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       wdog_rst_req;
  logic       rst_dom0;
  logic       rst_dom1;
  logic       rst_dom2;
  logic       seq_busy;
  logic       seq_done;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  sirv_rst_seq_ctrl #(.HOLD_CYC(HOLD), .STEP_CYC(STEP)) dut (
    .clock        (clock),
    .reset        (reset),
    .test_mode    (test_mode),
    .pll_lock     (pll_lock),
    .sw_rst_req   (sw_rst_req),
    .wdog_rst_req (wdog_rst_req),
    .rst_dom0     (rst_dom0),
    .rst_dom1     (rst_dom1),
    .rst_dom2     (rst_dom2),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .rst_cause    (rst_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t_m counts cycles spent holding since the last restart; rel_m counts
  // cycles since lock was accepted (-1 while holding or waiting for lock).
  int         t_m     = 0;
  int         rel_m   = -1;
  logic [1:0] cause_m = 2'd0;
  bit         s1_m    = 0;
  bit         s2_m    = 0;

  always @(posedge clock) begin
    bit lk;
    bit in_run;
    bit loss;
    lk     = s2_m;
    in_run = (rel_m >= 2 * STEP);
    loss   = in_run && !lk;
    if (reset) begin
      t_m = 0; rel_m = -1; cause_m = 2'd0; s1_m = 0; s2_m = 0;
    end else begin
      if (wdog_rst_req || sw_rst_req || loss) begin
        t_m = 0;
        rel_m = -1;
        cause_m = wdog_rst_req ? 2'd2 : (loss ? 2'd3 : 2'd1);
      end else if (rel_m >= 0) begin
        if (rel_m < RELMAX) rel_m = rel_m + 1;
      end else if (t_m >= HOLD) begin
        if (lk) rel_m = 0;
      end else begin
        t_m = t_m + 1;
      end
      s2_m = s1_m;
      s1_m = pll_lock;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic e0, e1, e2;
      e0 = test_mode ? reset : !(rel_m >= 0);
      e1 = test_mode ? reset : !(rel_m >= STEP);
      e2 = test_mode ? reset : !(rel_m >= 2 * STEP);
      chk("m_dom0", rst_dom0, e0);
      chk("m_dom1", rst_dom1, e1);
      chk("m_dom2", rst_dom2, e2);
      chk("m_busy", seq_busy, !(rel_m >= 2 * STEP));
      chk("m_done", seq_done, rel_m == 2 * STEP);
      chk("m_cause", rst_cause, cause_m);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Edges until rst_dom0 reaches the given level, -1 on timeout.
  task automatic wait_dom0(input logic lvl, input int budget, output int lat);
    lat = -1;
    for (int j = 1; j <= budget; j++) begin
      step();
      if (rst_dom0 === lvl) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic wait_dom1_low(input int budget, output int lat);
    lat = -1;
    for (int j = 1; j <= budget; j++) begin
      step();
      if (rst_dom1 === 1'b0) begin
        lat = j;
        break;
      end
    end
  endtask

  initial begin
    int f0, f1, f2, done_e, done_cnt, lat;
    reset = 1'b1; test_mode = 1'b0; pll_lock = 1'b1;
    sw_rst_req = 1'b0; wdog_rst_req = 1'b0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_dom0", rst_dom0, 1);
    chk("rst_dom2", rst_dom2, 1);
    chk("rst_busy", seq_busy, 1);
    chk("rst_done", seq_done, 0);
    chk("rst_cause", rst_cause, 0);

    // Power-on schedule.
    reset = 1'b0;
    f0 = -1; f1 = -1; f2 = -1; done_e = -1; done_cnt = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (!rst_dom0 && f0 < 0) f0 = e;
      if (!rst_dom1 && f1 < 0) f1 = e;
      if (!rst_dom2 && f2 < 0) f2 = e;
      if (seq_done) begin done_cnt++; done_e = e; end
    end
    chk("por_dom0_edge", f0, 17);
    chk("por_dom1_edge", f1, 25);
    chk("por_dom2_edge", f2, 33);
    chk("por_done_edge", done_e, 33);
    chk("por_done_cnt", done_cnt, 1);
    chk("por_cause", rst_cause, 0);

    // Late PLL lock.
    reset = 1'b1; pll_lock = 1'b0;
    step();
    reset = 1'b0;
    repeat (50) step();
    chk("lock_wait_dom0", rst_dom0, 1);
    chk("lock_wait_busy", seq_busy, 1);
    pll_lock = 1'b1;
    wait_dom0(1'b0, 10, lat);
    chk("lock_latency", lat, 3);
    repeat (20) step();
    chk("lock_run", seq_busy, 0);

    // Software restart from RUN.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("sw_dom0", rst_dom0, 1);
    chk("sw_dom1", rst_dom1, 1);
    chk("sw_dom2", rst_dom2, 1);
    chk("sw_cause", rst_cause, 1);
    chk("sw_busy", seq_busy, 1);
    wait_dom0(1'b0, 40, lat);
    chk("sw_dom0_lat", lat, 17);

    // Watchdog and software together in STEP1.
    sw_rst_req = 1'b1; wdog_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0; wdog_rst_req = 1'b0;
    chk("wd_cause", rst_cause, 2);
    chk("wd_dom0", rst_dom0, 1);
    wait_dom0(1'b0, 40, lat);
    chk("wd_dom0_lat", lat, 17);
    repeat (20) step();
    chk("wd_run", seq_busy, 0);

    // Lock loss in RUN, then ignored loss in STEP2.
    pll_lock = 1'b0;
    wait_dom0(1'b1, 10, lat);
    chk("ll_latency", lat, 3);
    chk("ll_cause", rst_cause, 3);
    pll_lock = 1'b1;
    wait_dom1_low(100, lat);
    chk("ll_step2_seen", lat > 0, 1);
    pll_lock = 1'b0;
    repeat (3) step();
    chk("ll_step2_dom0", rst_dom0, 0);
    chk("ll_step2_cause", rst_cause, 3);
    pll_lock = 1'b1;
    repeat (20) step();
    chk("ll_run", seq_busy, 0);

    // DFT bypass with reset toggled mid-STEP2.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    wait_dom1_low(100, lat);
    chk("tm_step2_seen", lat > 0, 1);
    test_mode = 1'b1;
    #1;
    chk("tm_dom0_lo", rst_dom0, 0);
    reset = 1'b1;
    #1;
    chk("tm_dom0_hi", rst_dom0, 1);
    chk("tm_dom2_hi", rst_dom2, 1);
    step();
    reset = 1'b0;
    #1;
    chk("tm_dom1_lo", rst_dom1, 0);
    step();
    test_mode = 1'b0;
    #1;
    chk("tm_hold_busy", seq_busy, 1);
    chk("tm_hold_dom2", rst_dom2, 1);

    // Randomized stimulus.
    for (int c = 0; c < 4000; c++) begin
      step();
      reset        = ($urandom_range(0, 299) == 0);
      sw_rst_req   = ($urandom_range(0, 99) == 0);
      wdog_rst_req = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 59) == 0) pll_lock = !pll_lock;
      if ($urandom_range(0, 79) == 0) test_mode = !test_mode;
    end
    reset = 1'b0; sw_rst_req = 1'b0; wdog_rst_req = 1'b0;
    repeat (5) step();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sirv_rst_seq_ctrl.md
SIRV_RST_SEQ_CTRL -- requirements
Module: sirv_rst_seq_ctrl

Interface
- REQ-001: The block SHALL have parameter HOLD_CYC, default 16, setting the all-domains-asserted hold length in cycles (legal 1..255).
- REQ-002: The block SHALL have parameter STEP_CYC, default 8, setting the gap in cycles between successive domain releases (legal 1..255).
- REQ-003: clock  input  1  single block clock; all state SHALL update on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high block reset (power-on cause).
- REQ-005: test_mode  input  1  DFT bypass; when high, all domain resets follow reset directly.
- REQ-006: pll_lock  input  1  asynchronous PLL lock indication; active high.
- REQ-007: sw_rst_req  input  1  software reset request; level, sampled each cycle.
- REQ-008: wdog_rst_req  input  1  watchdog reset request; level, sampled each cycle.
- REQ-009: rst_dom0 / rst_dom1 / rst_dom2  output  1 each  active-high domain resets, released in order 0, 1, 2.
- REQ-010: seq_busy  output  1  high whenever the state is not RUN.
- REQ-011: seq_done  output  1  one-cycle pulse in the first cycle of RUN.
- REQ-012: rst_cause  output  2  last reset cause: 0 POR, 1 SW, 2 WDOG, 3 LOCK_LOSS.

Function
- REQ-013: pll_lock SHALL pass through a 2-flop synchronizer (flops cleared by reset) before use; lock_s denotes the synchronized value.
- REQ-014: The FSM SHALL have states HOLD, LOCK, STEP1, STEP2, RUN, plus an 8-bit cycle counter cleared on every state entry.
- REQ-015: HOLD SHALL last exactly HOLD_CYC cycles, then go to LOCK.
- REQ-016: LOCK SHALL wait until lock_s is 1, then go to STEP1; with lock_s already 1, LOCK lasts 1 cycle. There is no timeout.
- REQ-017: STEP1 and STEP2 SHALL each last exactly STEP_CYC cycles, then go to STEP2 and RUN respectively.
- REQ-018: Outputs SHALL be registered and follow this release schedule:
  - rst_dom0 = 0 in STEP1, STEP2 and RUN;
  - rst_dom1 = 0 in STEP2 and RUN;
  - rst_dom2 = 0 in RUN only;
  - each output is 1 in every other state.
- REQ-019: A restart event SHALL occur when wdog_rst_req, sw_rst_req, or (state==RUN and lock_s==0) is sampled high.
- REQ-020: On a restart event, the next state SHALL be HOLD with the counter cleared, and all three domain resets SHALL be 1 from the next cycle.
- REQ-021: A restart event SHALL apply in any state, including mid-HOLD, where the hold restarts from zero.
- REQ-022: Cause priority for simultaneous events SHALL be WDOG > LOCK_LOSS > SW; rst_cause is updated on the same edge as the transition to HOLD.
- REQ-023: A request held high SHALL keep the FSM in HOLD with the counter at 0; the sequence resumes in the cycle after release.
- REQ-024: Loss of lock_s while in LOCK, STEP1 or STEP2 SHALL NOT be a restart event.
  - LOCK keeps waiting for lock_s.
  - In STEP1 and STEP2 the loss is ignored.
- REQ-025: seq_done SHALL pulse once per entry into RUN and SHALL NOT pulse again while the FSM stays in RUN.
- REQ-026: When test_mode=1, rst_dom0..2 SHALL equal reset combinationally; the FSM, seq_busy, seq_done and rst_cause keep their normal behaviour.

Reset
- REQ-027: While reset=1 the block SHALL hold:
  - state=HOLD, counter=0, synchronizer flops=0;
  - rst_dom0..2=1, seq_busy=1, seq_done=0, rst_cause=0.
- REQ-028: reset SHALL override every restart event and cause update.

Verification
- REQ-029: Power-on: defaults, pll_lock=1, reset released; edge 1 is the first edge with reset low.
  - Required: rst_dom0 falls after edge 17, rst_dom1 after edge 25, rst_dom2 after edge 33.
  - Required: seq_done is high for the single cycle after edge 33 and rst_cause=0.
- REQ-030: pll_lock=0 until cycle 50, then 1. Required: FSM waits in LOCK; rst_dom0 falls exactly 3 edges after pll_lock rises (2 synchronizer edges + 1 LOCK exit edge).
- REQ-031: In RUN, assert sw_rst_req for 1 cycle.
  - Required: all domains are 1 on the next cycle, rst_cause=1, seq_busy=1.
  - Required: the full schedule repeats (dom0 released 17 cycles after the restart edge).
- REQ-032: In STEP1, sw_rst_req and wdog_rst_req are asserted in the same cycle. Required: rst_cause=2, rst_dom0 returns to 1, HOLD restarts from counter 0.
- REQ-033: In RUN, drop pll_lock. Required: restart 3 edges later with rst_cause=3; a later drop during STEP2 causes no restart.
- REQ-034: test_mode=1 and reset toggled mid-STEP2. Required: rst_dom0..2 track reset in the same cycle; the FSM returns to HOLD under reset.
